uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmitter (i_TX_DV / i_TX_Byte / o_TX_Active / o_TX_Done interface) between NUM_REQ byte-stream requesters.
- Grants whole messages, delimited by a per-byte "last" flag, in round-robin order, so messages never interleave on the serial line.
- Sits between debug/status producers (packet monitors, counters dump) and the single UART transmitter.
- Inserts a programmable idle gap between messages.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- GAP_CLKS, 434, idle clocks between end of one message and start of the next (0 = no gap)

Ports:
- i_Clock  in  1  system clock
- i_Rst_n  in  1  synchronous active-low reset
- i_Req_Valid  in  NUM_REQ  per-requester byte valid
- i_Req_Byte  in  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k]
- i_Req_Last  in  NUM_REQ  byte is the final byte of its message
- o_Req_Ready  out  NUM_REQ  one-cycle accept strobe; a byte transfers when valid and ready are both high
- o_Grant  out  NUM_REQ  one-hot, current message owner
- o_TX_DV  out  1  one-cycle start strobe to the transmitter
- o_TX_Byte  out  8  byte to the transmitter, registered
- i_TX_Active  in  1  transmitter busy
- i_TX_Done  in  1  transmitter done (high for 2 consecutive clocks per byte)
- o_Busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (i_Rst_n=0 at a clock edge): state=SYNC; o_Req_Ready=0, o_Grant=0, o_TX_DV=0, o_TX_Byte=0, o_Busy=1 (SYNC is a non-IDLE state); RR pointer=NUM_REQ-1, so requester 0 has first priority; gap counter=0.
- Reset mid-byte: the transmitter has no reset and finishes the byte on its own. A partially sent message is abandoned, and its remaining bytes are treated as a new message.
- SYNC: wait until i_TX_Active=0 and i_TX_Done=0 for one sampled cycle, then go to IDLE.
- IDLE: o_Busy=0. If any i_Req_Valid is set, pick the first valid requester searching upward from pointer+1 with wrap. Set o_Grant one-hot, set pointer to the winner, go to ISSUE. Arbitration takes 1 cycle.
- ISSUE: if the granted requester has valid=1:
  - assert o_Req_Ready[g] and o_TX_DV for exactly 1 cycle;
  - register o_TX_Byte = the granted byte;
  - latch last_flag;
  - go to WAIT_DONE.
- ISSUE with valid=0: hold the grant and wait. The line stays idle with no timeout; the owner must finish its message.
- WAIT_DONE: wait for i_TX_Done=1, then go to WAIT_CLR.
- WAIT_CLR: wait for i_TX_Done=0 and i_TX_Active=0. Then:
  - if last_flag=0, go to ISSUE (same owner);
  - otherwise clear o_Grant, load the gap counter with GAP_CLKS, go to GAP.
- GAP: decrement each cycle; go to IDLE when the count reaches 0. With GAP_CLKS=0, go straight from WAIT_CLR to IDLE.
- Only the granted requester ever sees ready. Non-granted valid signals are ignored but remain pending; requesters must hold valid/byte/last stable until ready.
- o_TX_DV is never asserted while i_TX_Active or i_TX_Done is high.
- Byte-to-byte latency within a message: i_TX_Done falls, then 1 cycle to ISSUE (DV) when valid is already high.
- Simultaneous requests resolve in round-robin order; a single requester re-wins immediately after its gap.
- Gap counter width: $clog2(GAP_CLKS+1), minimum 1.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (SYNC, IDLE, ISSUE, WAIT_DONE, WAIT_CLR, GAP);
  - UART_BYTE_W=8;
  - CLKS_PER_BIT default 217, which GAP_CLKS derivations use (GAP_CLKS = 2*CLKS_PER_BIT).
- One sub-module: rr_arbiter (combinational winner selection from request vector and pointer, parameter N). Reusable elsewhere.

Test Plan:
- Reset then single request 0, message 0x41,0x42 (last on 0x42) -> UART line carries 0x41 then 0x42. Exactly 2 o_TX_DV pulses. o_Req_Ready[0] is pulsed twice. o_Busy returns to 0 after GAP_CLKS (override to 10).
- Requesters 0 and 2 valid together with 1-byte messages 0xA0 and 0xC2 -> 0xA0 sent first, then 0xC2. Grant is never held by both; the GAP of 10 cycles appears between them.
- Requester 1 sends a 3-byte message while requester 3 asserts valid after byte 1 -> all three bytes from 1 are sent before any byte from 3; o_Grant stays 4'b0010 throughout.
- All four requesters continuously valid with 1-byte messages, 8 messages -> grant order 0,1,2,3,0,1,2,3.
- Owner drops valid for 1000 cycles mid-message -> no o_TX_DV during the stall, grant is held, and the message resumes correctly.
- i_Rst_n pulsed low for 1 cycle while the transmitter is mid data bit -> all outputs are at reset values the next cycle. The first new o_TX_DV occurs only after i_TX_Done has pulsed and cleared, and the transmitter shows no corrupted start.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, bit timing defaults and the
// transmit-arbiter FSM encoding.
package uart_pkg;

    localparam int UART_BYTE_W      = 8;
    localparam int CLKS_PER_BIT     = 217;
    localparam int DEFAULT_GAP_CLKS = 2 * CLKS_PER_BIT;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_WAIT_CLR,
        ST_GAP
    } tx_state_t;

    // A zero-length gap still needs a one-bit counter to keep the port legal.
    function automatic int gap_cnt_w(input int clks);
        return (clks < 1) ? 1 : $clog2(clks + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: first set request strictly after
// the pointer, searching upward with wrap-around.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_vld
);

    localparam int IW = $clog2(N);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!gnt_vld && req[(int'(ptr) + i) % N]) begin
                gnt_vld                   = 1'b1;
                gnt[(int'(ptr) + i) % N]  = 1'b1;
                gnt_idx                   = IW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 transmitter between NUM_REQ byte streams, granting whole
// messages round-robin with a programmable idle gap between them.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int GAP_CLKS = DEFAULT_GAP_CLKS
) (
    input  logic                           i_Clock,
    input  logic                           i_Rst_n,
    input  logic [NUM_REQ-1:0]             i_Req_Valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]             i_Req_Last,
    output logic [NUM_REQ-1:0]             o_Req_Ready,
    output logic [NUM_REQ-1:0]             o_Grant,
    output logic                           o_TX_DV,
    output logic [UART_BYTE_W-1:0]         o_TX_Byte,
    input  logic                           i_TX_Active,
    input  logic                           i_TX_Done,
    output logic                           o_Busy
);

    localparam int                IDX_W    = $clog2(NUM_REQ);
    localparam int                GAP_W    = gap_cnt_w(GAP_CLKS);
    localparam logic [IDX_W-1:0]  PTR_INIT = IDX_W'(NUM_REQ - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CLKS);

    tx_state_t              state, state_nxt;
    logic [NUM_REQ-1:0]     grant, grant_nxt;
    logic [IDX_W-1:0]       ptr, ptr_nxt;
    logic                   last_flag, last_nxt;
    logic [GAP_W-1:0]       gap_cnt, gap_nxt;
    logic                   tx_dv, tx_dv_nxt;
    logic [UART_BYTE_W-1:0] tx_byte, byte_nxt;
    logic [NUM_REQ-1:0]     ready, ready_nxt;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_vld;

    logic                   owner_valid;
    logic                   owner_last;
    logic [UART_BYTE_W-1:0] owner_byte;
    logic                   tx_idle;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr_arbiter (
        .req     (i_Req_Valid),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // The pointer always holds the current (or most recent) owner's index.
    assign owner_valid = i_Req_Valid[ptr];
    assign owner_last  = i_Req_Last[ptr];
    assign owner_byte  = i_Req_Byte[UART_BYTE_W*int'(ptr) +: UART_BYTE_W];
    assign tx_idle     = !i_TX_Active && !i_TX_Done;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state     <= ST_SYNC;
            grant     <= '0;
            ptr       <= PTR_INIT;
            last_flag <= 1'b0;
            gap_cnt   <= '0;
            tx_dv     <= 1'b0;
            tx_byte   <= '0;
            ready     <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            ptr       <= ptr_nxt;
            last_flag <= last_nxt;
            gap_cnt   <= gap_nxt;
            tx_dv     <= tx_dv_nxt;
            tx_byte   <= byte_nxt;
            ready     <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        last_nxt  = last_flag;
        gap_nxt   = gap_cnt;
        tx_dv_nxt = 1'b0;
        byte_nxt  = tx_byte;
        ready_nxt = '0;
        case (state)
            ST_SYNC: begin
                if (tx_idle) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (arb_vld) begin
                    grant_nxt = arb_gnt;
                    ptr_nxt   = arb_idx;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // An owner that stalls mid-message keeps the line; no timeout.
                if (owner_valid && tx_idle) begin
                    tx_dv_nxt = 1'b1;
                    ready_nxt = grant;
                    byte_nxt  = owner_byte;
                    last_nxt  = owner_last;
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (i_TX_Done) state_nxt = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                if (tx_idle) begin
                    if (!last_flag) begin
                        state_nxt = ST_ISSUE;
                    end else begin
                        grant_nxt = '0;
                        if (GAP_CLKS == 0) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            gap_nxt   = GAP_LOAD;
                            state_nxt = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                gap_nxt = gap_cnt - 1'b1;
                if (gap_cnt <= GAP_W'(1)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_SYNC;
        endcase
    end

    assign o_Req_Ready = ready;
    assign o_Grant     = grant;
    assign o_TX_DV     = tx_dv;
    assign o_TX_Byte   = tx_byte;
    assign o_Busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter with a message-level
// round-robin reference model and a simple timed transmitter model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int GAP       = 10;
    localparam int BYTE_CLKS = 20;
    localparam int QDEPTH    = 256;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [8*NUM_REQ-1:0]   req_byte = '0;
    logic [NUM_REQ-1:0]     req_last = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     grant;
    logic                   tx_dv;
    logic [7:0]             tx_byte;
    logic                   tx_active = 1'b0;
    logic                   tx_done = 1'b0;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    // Requester stimulus storage: bit 8 is the last flag.
    logic [8:0] rq_mem [NUM_REQ][QDEPTH];
    int rq_head  [NUM_REQ];
    int rq_tail  [NUM_REQ];
    int stg_tail [NUM_REQ];
    int stall_len[NUM_REQ];
    int stall_cnt[NUM_REQ];
    int ready_cnt[NUM_REQ];
    bit hold     [NUM_REQ];

    logic [10:0] exp_q[$];
    int mptr = NUM_REQ - 1;

    int tx_busy_cnt = 0;
    int tx_done_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .GAP_CLKS (GAP)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Req_Valid (req_valid),
        .i_Req_Byte  (req_byte),
        .i_Req_Last  (req_last),
        .o_Req_Ready (req_ready),
        .o_Grant     (grant),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .i_TX_Active (tx_active),
        .i_TX_Done   (tx_done),
        .o_Busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter model: no reset, busy BYTE_CLKS cycles, then Done for 2 clocks.
    always @(posedge clk) begin
        if (tx_done_cnt > 0) begin
            tx_done_cnt <= tx_done_cnt - 1;
            if (tx_done_cnt == 1) tx_done <= 1'b0;
        end
        if (tx_busy_cnt > 0) begin
            tx_busy_cnt <= tx_busy_cnt - 1;
            if (tx_busy_cnt == 1) begin
                tx_active   <= 1'b0;
                tx_done     <= 1'b1;
                tx_done_cnt <= 2;
            end
        end else if (tx_dv) begin
            tx_active   <= 1'b1;
            tx_busy_cnt <= BYTE_CLKS;
        end
    end

    // Requester drivers: present the queue head, hold it until ready, stall on request.
    always @(negedge clk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready[k] && req_valid[k]) begin
                ready_cnt[k]++;
                if (!rq_mem[k][rq_head[k]][8]) stall_cnt[k] = stall_len[k];
                rq_head[k]++;
            end else if (stall_cnt[k] > 0) begin
                stall_cnt[k]--;
            end
            if (rq_head[k] < rq_tail[k] && stall_cnt[k] == 0 && !hold[k]) begin
                req_valid[k]        = 1'b1;
                req_byte[8*k +: 8]  = rq_mem[k][rq_head[k]][7:0];
                req_last[k]         = rq_mem[k][rq_head[k]][8];
            end else begin
                req_valid[k]        = 1'b0;
                req_byte[8*k +: 8]  = 8'($urandom);
                req_last[k]         = 1'($urandom);
            end
        end
    end

    // Monitor: pops the scoreboard on each transmitter start strobe.
    initial begin
        logic [10:0] e;
        logic [NUM_REQ-1:0] prev_grant;
        bit gap_arm;
        int gap_n;
        int ow;
        prev_grant = '0;
        gap_arm = 1'b0;
        gap_n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                gap_arm    = 1'b0;
                prev_grant = '0;
            end else begin
                if (tx_dv) begin
                    chk("dv_tx_idle", {30'd0, tx_active, tx_done}, 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_dv", 32'd1, 32'd0);
                    end else begin
                        e  = exp_q.pop_front();
                        ow = int'(e[10:8]);
                        chk("tx_byte", {24'd0, tx_byte}, {24'd0, e[7:0]});
                        chk("grant_owner", {28'd0, grant}, 32'(1 << ow));
                        chk("ready_owner", {28'd0, req_ready}, 32'(1 << ow));
                        chk("dv_during_stall", stall_cnt[ow], 32'd0);
                    end
                end else if (req_ready != '0) begin
                    chk("ready_without_dv", {28'd0, req_ready}, 32'd0);
                end
                for (int k = 0; k < NUM_REQ; k++)
                    if (stall_cnt[k] > 0) chk("grant_held", {28'd0, grant}, 32'(1 << k));
                if (prev_grant != '0 && grant == '0) begin
                    gap_arm = 1'b1;
                    gap_n   = 0;
                end
                if (gap_arm) begin
                    if (busy) gap_n++;
                    else begin
                        chk("gap_len", gap_n, GAP);
                        gap_arm = 1'b0;
                    end
                end
                prev_grant = grant;
            end
        end
    end

    task automatic clear_q();
        for (int k = 0; k < NUM_REQ; k++) begin
            rq_head[k]   = 0;
            rq_tail[k]   = 0;
            stg_tail[k]  = 0;
            stall_len[k] = 0;
            stall_cnt[k] = 0;
            ready_cnt[k] = 0;
            hold[k]      = 1'b0;
        end
    endtask

    task automatic add_byte(input int k, input logic [7:0] b, input bit last);
        rq_mem[k][stg_tail[k]] = {last, b};
        stg_tail[k]++;
    endtask

    task automatic release_stage();
        for (int k = 0; k < NUM_REQ; k++) rq_tail[k] = stg_tail[k];
    endtask

    // Reference: whole messages, next owner = first requester after the
    // previous owner that still has a message pending.
    task automatic commit_model();
        int pos[NUM_REQ];
        int found;
        int k;
        bit last;
        for (int i = 0; i < NUM_REQ; i++) pos[i] = rq_head[i];
        while (1) begin
            found = -1;
            for (int i = 1; i <= NUM_REQ; i++) begin
                k = (mptr + i) % NUM_REQ;
                if (found < 0 && pos[k] < stg_tail[k]) found = k;
            end
            if (found < 0) break;
            do begin
                last = rq_mem[found][pos[found]][8];
                exp_q.push_back({3'(found), rq_mem[found][pos[found]][7:0]});
                pos[found]++;
            end while (!last && pos[found] < stg_tail[found]);
            mptr = found;
        end
        release_stage();
    endtask

    task automatic push_exp(input int k, input logic [7:0] b);
        exp_q.push_back({3'(k), b});
    endtask

    task automatic reset_pulse(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_dv", {31'd0, tx_dv}, 32'd0);
        chk("rst_byte", {24'd0, tx_byte}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0 | 1'b1;
        mptr  = NUM_REQ - 1;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        bit drained;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #2;
            drained = 1'b1;
            for (int k = 0; k < NUM_REQ; k++) if (rq_head[k] < rq_tail[k]) drained = 1'b0;
            if (drained && exp_q.size() == 0 && !busy && !tx_active && !tx_done) done = 1'b1;
        end
        if (!done) begin
            chk("idle_timeout", {31'd0, busy}, 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic wait_ready(input int k, input int n, input int budget);
        int i;
        i = 0;
        while (ready_cnt[k] < n && i < budget) begin
            @(posedge clk);
            #2;
            i++;
        end
        if (ready_cnt[k] < n) chk("ready_timeout", ready_cnt[k], n);
    endtask

    initial begin
        int nm;
        int len;
        clear_q();
        reset_pulse(3);

        // Single two-byte message from requester 0.
        clear_q();
        add_byte(0, 8'h41, 1'b0);
        add_byte(0, 8'h42, 1'b1);
        commit_model();
        wait_idle(2000);
        chk("s1_ready_cnt", ready_cnt[0], 2);

        // Requesters 0 and 2 together from a fresh pointer.
        reset_pulse(1);
        clear_q();
        add_byte(0, 8'hA0, 1'b1);
        add_byte(2, 8'hC2, 1'b1);
        commit_model();
        wait_idle(2000);

        // Requester 3 turns valid after requester 1's first byte.
        clear_q();
        hold[3] = 1'b1;
        add_byte(1, 8'h11, 1'b0);
        add_byte(1, 8'h12, 1'b0);
        add_byte(1, 8'h13, 1'b1);
        add_byte(3, 8'h33, 1'b1);
        push_exp(1, 8'h11);
        push_exp(1, 8'h12);
        push_exp(1, 8'h13);
        push_exp(3, 8'h33);
        release_stage();
        wait_ready(1, 1, 2000);
        hold[3] = 1'b0;
        wait_idle(2000);
        mptr = 3;

        // All four continuously valid, two one-byte messages each.
        clear_q();
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < NUM_REQ; k++) add_byte(k, 8'($urandom), 1'b1);
        commit_model();
        wait_idle(4000);

        // Owner stalls for 1000 cycles mid-message.
        clear_q();
        stall_len[2] = 1000;
        add_byte(2, 8'h5A, 1'b0);
        add_byte(2, 8'h5B, 1'b1);
        commit_model();
        wait_idle(4000);

        // Reset while the transmitter is mid-byte; remaining bytes form a new message.
        clear_q();
        add_byte(1, 8'hD1, 1'b0);
        add_byte(1, 8'hD2, 1'b0);
        add_byte(1, 8'hD3, 1'b1);
        commit_model();
        wait_ready(1, 1, 2000);
        repeat (8) @(posedge clk);
        reset_pulse(1);
        wait_idle(4000);
        mptr = 1;

        // Randomised rounds.
        for (int r = 0; r < 6; r++) begin
            clear_q();
            for (int k = 0; k < NUM_REQ; k++) begin
                stall_len[k] = $urandom_range(0, 15);
                if ($urandom_range(0, 3) != 0) begin
                    nm = $urandom_range(1, 3);
                    for (int m = 0; m < nm; m++) begin
                        len = $urandom_range(1, 4);
                        for (int b = 0; b < len; b++) add_byte(k, 8'($urandom), b == len - 1);
                    end
                end
            end
            commit_model();
            wait_idle(6000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
